// File: rtl/mux_rr_reg.sv
// Registered N-channel select mux with fixed-priority or round-robin arbitration.
// Loads the winning channel's data and index one cycle after the request is sampled.
module mux_rr_reg #(
    parameter  int NCH = 3,
    parameter  int W   = 4,
    localparam int GW  = $clog2(NCH)
) (
    input  logic             clock,
    input  logic             rst_,
    input  logic [NCH*W-1:0] ip,
    input  logic [NCH-1:0]   sel,
    input  logic             rr_mode,
    output logic [W-1:0]     mux_op,
    output logic             op_valid,
    output logic [GW-1:0]    grant
);

    logic [W-1:0]  mux_q, mux_d;
    logic          valid_q, valid_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;

    logic          any_req;
    logic [GW-1:0] fix_idx;
    logic [NCH-1:0] rot_sel;
    logic [GW-1:0] rot_idx;
    logic [GW:0]   rr_sum;
    logic [GW-1:0] rr_idx;
    logic [GW-1:0] win_idx;
    logic [W-1:0]  win_data;
    logic [GW-1:0] grant_inc;

    // Round-robin search: rotate requests so rr_ptr lands at bit 0, take the
    // lowest set bit, then add the pointer back with an explicit modulo-NCH wrap.
    always_comb begin : pick
        any_req = |sel;
        fix_idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (sel[k]) fix_idx = GW'(k);
        end
        rot_sel = NCH'({sel, sel} >> rr_ptr_q);
        rot_idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (rot_sel[k]) rot_idx = GW'(k);
        end
        rr_sum = {1'b0, rr_ptr_q} + {1'b0, rot_idx};
        if (rr_sum >= (GW+1)'(NCH)) rr_sum = rr_sum - (GW+1)'(NCH);
        rr_idx  = rr_sum[GW-1:0];
        win_idx = rr_mode ? rr_idx : fix_idx;
        win_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (win_idx == GW'(k)) win_data = ip[k*W +: W];
        end
    end

    always_comb begin : next_state
        mux_d    = mux_q;
        grant_d  = grant_q;
        valid_d  = any_req;
        rr_ptr_d = rr_ptr_q;
        if (any_req) begin
            mux_d   = win_data;
            grant_d = win_idx;
            // The pointer only advances on round-robin grants; fixed-priority leaves it alone.
            if (rr_mode) rr_ptr_d = (win_idx == GW'(NCH - 1)) ? '0 : win_idx + GW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_) begin
            mux_q    <= '0;
            valid_q  <= 1'b0;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            mux_q    <= mux_d;
            valid_q  <= valid_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign mux_op   = mux_q;
    assign op_valid = valid_q;
    assign grant    = grant_q;

    // Expected successor of the current grant under continuous all-request round-robin.
    assign grant_inc = (grant_q == GW'(NCH - 1)) ? '0 : grant_q + GW'(1);

    for (genvar k = 0; k < NCH; k++) begin : g_fixed
        localparam logic [NCH-1:0] LOWER = NCH'((64'(1) << k) - 64'(1));
        a_fixed: assert property (@(posedge clock) disable iff (!rst_)
            (!rr_mode && sel[k] && ((sel & LOWER) == '0))
            |=> (mux_op == $past(ip[k*W +: W]) && grant == GW'(k)))
            else $error("A_FIXED violated on channel %0d", k);
    end

    a_hold: assert property (@(posedge clock) disable iff (!rst_)
        (sel == '0) |=> ($stable(mux_op) && $stable(grant) && !op_valid))
        else $error("A_HOLD violated, channel %0d", grant);

    a_valid: assert property (@(posedge clock) disable iff (!rst_)
        (|sel) |=> op_valid)
        else $error("A_VALID violated, channel %0d", grant);

    a_onehot_legal: assert property (@(posedge clock) disable iff (!rst_)
        op_valid |-> ({1'b0, grant} < (GW+1)'(NCH)))
        else $error("A_ONEHOT_LEGAL violated, channel %0d", grant);

    // Two back-to-back all-request round-robin cycles must grant consecutive channels,
    // which keeps every NCH-long window of grants free of repeats.
    a_rr_fair: assert property (@(posedge clock) disable iff (!rst_)
        (rr_mode && (&sel) && $past(rr_mode && (&sel) && rst_))
        |=> (grant == $past(grant_inc)))
        else $error("A_RR_FAIR violated, channel %0d", grant);

endmodule

// File: tb/tb_mux_rr_reg.sv
// Bench for mux_rr_reg: a 3-channel and a 5-channel instance driven side by side,
// directed vector table, hand sequences and randomized cycles against a reference model.
module tb_mux_rr_reg;

    logic        clock = 1'b0;
    logic        rst_;
    logic [11:0] ip3;
    logic [2:0]  sel3;
    logic        mode3;
    logic [3:0]  mux3;
    logic        v3;
    logic [1:0]  g3;
    logic [19:0] ip5;
    logic [4:0]  sel5;
    logic        mode5;
    logic [3:0]  mux5;
    logic        v5;
    logic [2:0]  g5;

    int checks = 0;
    int errors = 0;

    // Reference model state per instance (0 = 3 channels, 1 = 5 channels)
    int m_ptr[2];
    int m_mux[2];
    int m_grant[2];
    int m_valid[2];

    logic [8:0] exp_q[$];

    typedef struct {
        logic [2:0] sel;
        logic       mode;
        logic [3:0] mux;
        logic [1:0] grant;
        logic       valid;
    } vec_t;

    vec_t tbl[15];

    mux_rr_reg #(.NCH(3), .W(4)) dut3 (
        .clock(clock), .rst_(rst_), .ip(ip3), .sel(sel3), .rr_mode(mode3),
        .mux_op(mux3), .op_valid(v3), .grant(g3)
    );

    mux_rr_reg #(.NCH(5), .W(4)) dut5 (
        .clock(clock), .rst_(rst_), .ip(ip5), .sel(sel5), .rr_mode(mode5),
        .mux_op(mux5), .op_valid(v5), .grant(g5)
    );

    // clock / reset
    always #5 clock = ~clock;

    function automatic void model_step(int inst, int n, bit r, logic [19:0] ip,
                                       logic [4:0] sel, bit mode);
        int winner;
        winner = -1;
        if (!r) begin
            m_ptr[inst] = 0; m_mux[inst] = 0; m_grant[inst] = 0; m_valid[inst] = 0;
            return;
        end
        if (mode) begin
            for (int i = 0; i < n; i++) begin
                int k;
                k = (m_ptr[inst] + i) % n;
                if (winner < 0 && sel[k]) winner = k;
            end
        end else begin
            for (int k = 0; k < n; k++) begin
                if (winner < 0 && sel[k]) winner = k;
            end
        end
        if (winner < 0) begin
            m_valid[inst] = 0;
        end else begin
            m_mux[inst]   = int'(ip[winner*4 +: 4]);
            m_grant[inst] = winner;
            m_valid[inst] = 1;
            if (mode) m_ptr[inst] = (winner + 1) % n;
        end
    endfunction

    // driver: apply one cycle to both instances, advance the model, sample after the edge
    task automatic step(input bit r, input logic [2:0] s3, input logic [11:0] i3, input bit md3,
                        input logic [4:0] s5, input logic [19:0] i5, input bit md5);
        rst_ = r;
        sel3 = s3; ip3 = i3; mode3 = md3;
        sel5 = s5; ip5 = i5; mode5 = md5;
        model_step(0, 3, r, {8'h00, i3}, {2'b00, s3}, md3);
        model_step(1, 5, r, i5, s5, md5);
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk3(input string name, input int mux, input int grant, input int valid);
        chk({name, ".mux3"}, int'(mux3), mux);
        chk({name, ".grant3"}, int'(g3), grant);
        chk({name, ".valid3"}, int'(v3), valid);
    endtask

    task automatic chk5(input string name, input int mux, input int grant, input int valid);
        chk({name, ".mux5"}, int'(mux5), mux);
        chk({name, ".grant5"}, int'(g5), grant);
        chk({name, ".valid5"}, int'(v5), valid);
    endtask

    initial begin
        logic [8:0] exp_v;
        logic [8:0] act_v;

        tbl[0]  = '{3'b110, 1'b0, 4'hB, 2'd1, 1'b1};
        tbl[1]  = '{3'b111, 1'b0, 4'hA, 2'd0, 1'b1};
        tbl[2]  = '{3'b000, 1'b0, 4'hA, 2'd0, 1'b0};
        tbl[3]  = '{3'b111, 1'b1, 4'hA, 2'd0, 1'b1};
        tbl[4]  = '{3'b111, 1'b1, 4'hB, 2'd1, 1'b1};
        tbl[5]  = '{3'b111, 1'b1, 4'hC, 2'd2, 1'b1};
        tbl[6]  = '{3'b111, 1'b1, 4'hA, 2'd0, 1'b1};
        tbl[7]  = '{3'b111, 1'b1, 4'hB, 2'd1, 1'b1};
        tbl[8]  = '{3'b111, 1'b1, 4'hC, 2'd2, 1'b1};
        tbl[9]  = '{3'b111, 1'b1, 4'hA, 2'd0, 1'b1};
        tbl[10] = '{3'b111, 1'b1, 4'hB, 2'd1, 1'b1};
        tbl[11] = '{3'b011, 1'b0, 4'hA, 2'd0, 1'b1};
        tbl[12] = '{3'b111, 1'b1, 4'hC, 2'd2, 1'b1};
        tbl[13] = '{3'b000, 1'b1, 4'hC, 2'd2, 1'b0};
        tbl[14] = '{3'b010, 1'b1, 4'hB, 2'd1, 1'b1};

        // Reset held with every channel requesting
        step(1'b0, 3'b111, 12'hFFF, 1'b0, 5'b11111, 20'hFFFFF, 1'b0);
        chk3("rst0", 0, 0, 0);
        chk5("rst0", 0, 0, 0);
        step(1'b0, 3'b111, 12'hFFF, 1'b0, 5'b11111, 20'hFFFFF, 1'b0);
        chk3("rst1", 0, 0, 0);
        step(1'b1, 3'b111, 12'hFFF, 1'b0, 5'b00000, 20'h54321, 1'b0);
        chk3("rst_release", 'hF, 0, 1);
        chk5("idle5", 0, 0, 0);

        // Directed vectors on the 3-channel instance, ip = {C, B, A}
        for (int i = 0; i < 15; i++) begin
            step(1'b1, tbl[i].sel, 12'hCBA, tbl[i].mode, 5'b00000, 20'h54321, 1'b0);
            chk3($sformatf("tbl%0d", i), int'(tbl[i].mux), int'(tbl[i].grant), int'(tbl[i].valid));
        end

        // Reset mid-stream with rr_ptr at 2; search restarts at channel 0
        step(1'b0, 3'b111, 12'hCBA, 1'b1, 5'b11111, 20'h54321, 1'b1);
        chk3("mid_rst", 0, 0, 0);
        step(1'b1, 3'b111, 12'hCBA, 1'b1, 5'b00000, 20'h54321, 1'b1);
        chk3("post_rst", 'hA, 0, 1);

        // Non-power-of-2 wrap on the 5-channel instance
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3'b000, 12'hCBA, 1'b0, 5'b10001, 20'h54321, 1'b1);
            chk5($sformatf("wrap5_%0d", i), (i % 2 == 0) ? 1 : 5, (i % 2 == 0) ? 0 : 4, 1);
        end
        step(1'b1, 3'b000, 12'hCBA, 1'b0, 5'b00100, 20'h54321, 1'b1);
        chk5("single5", 3, 2, 1);
        step(1'b1, 3'b000, 12'hCBA, 1'b0, 5'b00000, 20'h54321, 1'b1);
        chk5("hold5", 3, 2, 0);

        // Randomized cycles against the model, realigned by a reset first
        step(1'b0, 3'b000, 12'h000, 1'b0, 5'b00000, 20'h00000, 1'b0);
        for (int n = 0; n < 400; n++) begin
            bit          r;
            logic [2:0]  s3;
            logic [4:0]  s5;
            logic [11:0] i3;
            logic [19:0] i5;
            r  = ($urandom_range(0, 31) != 0);
            s3 = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'($urandom);
            s5 = ($urandom_range(0, 3) == 0) ? 5'b11111 : 5'($urandom);
            i3 = 12'($urandom);
            i5 = 20'($urandom);
            step(r, s3, i3, 1'($urandom), s5, i5, 1'($urandom));
            exp_q.push_back({1'(m_valid[0]), 4'(m_grant[0]), 4'(m_mux[0])});
            exp_q.push_back({1'(m_valid[1]), 4'(m_grant[1]), 4'(m_mux[1])});
            exp_v = exp_q.pop_front();
            act_v = {v3, {2'b00, g3}, mux3};
            chk($sformatf("rand3_%0d", n), int'(act_v), int'(exp_v));
            exp_v = exp_q.pop_front();
            act_v = {v5, {1'b0, g5}, mux5};
            chk($sformatf("rand5_%0d", n), int'(act_v), int'(exp_v));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
